// File: rtl/phys_regfile_mp.sv
// phys_regfile_mp: multi-port physical register file with ready bits, write bypass and wakeup broadcast
module phys_regfile_mp #(
    parameter int XLEN      = 32,
    parameter int NUM_PREGS = 64,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int BYPASS    = 1,
    parameter int PW        = $clog2(NUM_PREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_en,
    input  logic [PW-1:0]          alloc_preg,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*PW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic [NUM_RD*PW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_ready,
    output logic [NUM_WR-1:0]      wakeup_valid,
    output logic [NUM_WR*PW-1:0]   wakeup_tag,
    output logic                   err_multi_wr
);
    logic [XLEN-1:0]      mem [NUM_PREGS];
    logic [NUM_PREGS-1:0] rdy;
    logic [NUM_WR-1:0]    we, wake;
    logic                 alloc_hit, conflict;

    assign alloc_hit = alloc_en && alloc_preg != '0;

    always_comb begin
        conflict = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
            we[k]   = wr_en[k] && !rst && wr_addr[k*PW +: PW] != '0;
            wake[k] = we[k] && !(alloc_hit && wr_addr[k*PW +: PW] == alloc_preg);
        end
        for (int j = 0; j < NUM_WR; j++)
            for (int k = j + 1; k < NUM_WR; k++)
                conflict |= we[j] && we[k] && wr_addr[j*PW +: PW] == wr_addr[k*PW +: PW];
    end

    // descending port order so the lowest-index port's data lands last and wins
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < NUM_PREGS; i++)
                mem[i] <= '0;
            rdy          <= NUM_PREGS'(1);
            wakeup_valid <= '0;
            wakeup_tag   <= '0;
            err_multi_wr <= 1'b0;
        end else begin
            for (int k = NUM_WR - 1; k >= 0; k--)
                if (we[k]) begin
                    mem[wr_addr[k*PW +: PW]] <= wr_data[k*XLEN +: XLEN];
                    rdy[wr_addr[k*PW +: PW]] <= 1'b1;
                end
            if (alloc_hit)
                rdy[alloc_preg] <= 1'b0;
            if (conflict)
                err_multi_wr <= 1'b1;
            wakeup_valid <= wake;
            for (int k = 0; k < NUM_WR; k++)
                if (wake[k])
                    wakeup_tag[k*PW +: PW] <= wr_addr[k*PW +: PW];
        end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [PW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            v;
        assign a = rd_addr[r*PW +: PW];
        always_comb begin
            d = mem[a];
            v = rdy[a];
            if (BYPASS != 0 && !(alloc_hit && alloc_preg == a))
                for (int k = NUM_WR - 1; k >= 0; k--)
                    if (we[k] && wr_addr[k*PW +: PW] == a) begin
                        d = wr_data[k*XLEN +: XLEN];
                        v = 1'b1;
                    end
        end
        assign rd_data[r*XLEN +: XLEN] = d;
        assign rd_ready[r]             = v;
    end
endmodule

// File: tb/tb_phys_regfile_mp.sv
// tb_phys_regfile_mp: scoreboard bench for phys_regfile_mp with default parameters
module tb_phys_regfile_mp;
    localparam int XLEN = 32;
    localparam int PW   = 6;
    localparam int NR   = 4;
    localparam int NW   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               alloc_en;
    logic [PW-1:0]      alloc_preg;
    logic [NW-1:0]      wr_en;
    logic [NW*PW-1:0]   wr_addr;
    logic [NW*XLEN-1:0] wr_data;
    logic [NR*PW-1:0]   rd_addr;
    logic [NR*XLEN-1:0] rd_data;
    logic [NR-1:0]      rd_ready;
    logic [NW-1:0]      wakeup_valid;
    logic [NW*PW-1:0]   wakeup_tag;
    logic               err_multi_wr;

    phys_regfile_mp dut (
        .clk(clk), .rst(rst), .alloc_en(alloc_en), .alloc_preg(alloc_preg),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_ready(rd_ready), .wakeup_valid(wakeup_valid),
        .wakeup_tag(wakeup_tag), .err_multi_wr(err_multi_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    localparam int K_DATA = 0, K_RDY = 1, K_WV = 2, K_TAG = 3, K_ERR = 4;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] observe(input int kind, input int port);
        case (kind)
            K_DATA:  return rd_data[port*XLEN +: XLEN];
            K_RDY:   return 32'(rd_ready[port]);
            K_WV:    return 32'(wakeup_valid);
            K_TAG:   return 32'(wakeup_tag[port*PW +: PW]);
            default: return 32'(err_multi_wr);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int kind, input int port, input logic [31:0] v);
        sb.push_back('{tag, kind, port, v});
    endtask

    task automatic drain();
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, observe(e.kind, e.port), e.exp);
        end
    endtask

    task automatic idle();
        wr_en    = '0;
        alloc_en = 1'b0;
    endtask

    task automatic rd_all(input int a);
        for (int p = 0; p < NR; p++) rd_addr[p*PW +: PW] = PW'(a);
    endtask

    task automatic wr(input int k, input int a, input logic [31:0] d);
        wr_en[k]                = 1'b1;
        wr_addr[k*PW +: PW]     = PW'(a);
        wr_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic alloc(input int a);
        alloc_en   = 1'b1;
        alloc_preg = PW'(a);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        alloc_preg = '0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_addr    = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state: p0 on ports 0/1, p5 on ports 2/3
        @(negedge clk);
        rd_addr[0*PW +: PW] = 6'd0;
        rd_addr[1*PW +: PW] = 6'd0;
        rd_addr[2*PW +: PW] = 6'd5;
        rd_addr[3*PW +: PW] = 6'd5;
        for (int p = 0; p < NR; p++) begin
            push("rst_data", K_DATA, p, 0);
            push("rst_rdy", K_RDY, p, p < 2 ? 1 : 0);
        end
        push("rst_err", K_ERR, 0, 0);
        push("rst_wv", K_WV, 0, 0);
        push("rst_tag0", K_TAG, 0, 0);
        push("rst_tag1", K_TAG, 1, 0);
        drain();

        // give p7 an old value, then reallocate it
        @(negedge clk);
        rd_all(7);
        wr(0, 7, 32'h1);
        @(negedge clk);
        idle();
        alloc(7);
        push("p7_old_rdy", K_RDY, 2, 1);
        push("p7_old_wv", K_WV, 0, 1);
        drain();
        @(negedge clk);
        idle();
        push("alloc_rdy0", K_RDY, 0, 0);
        push("alloc_data_kept", K_DATA, 0, 1);
        push("alloc_wv", K_WV, 0, 0);
        drain();
        @(negedge clk);
        wr(1, 7, 32'hDEADBEEF);
        push("byp_data", K_DATA, 0, 32'hDEADBEEF);
        push("byp_rdy", K_RDY, 3, 1);
        drain();
        @(negedge clk);
        idle();
        push("p7_data", K_DATA, 1, 32'hDEADBEEF);
        push("p7_rdy", K_RDY, 1, 1);
        push("p7_wv", K_WV, 0, 2);
        push("p7_tag1", K_TAG, 1, 7);
        drain();

        // same-address conflict on p9
        @(negedge clk);
        rd_all(9);
        wr(0, 9, 32'h11);
        wr(1, 9, 32'h22);
        push("cf_byp", K_DATA, 2, 32'h11);
        push("cf_err_pre", K_ERR, 0, 0);
        drain();
        @(negedge clk);
        idle();
        push("cf_data", K_DATA, 3, 32'h11);
        push("cf_rdy", K_RDY, 0, 1);
        push("cf_err", K_ERR, 0, 1);
        push("cf_wv", K_WV, 0, 3);
        push("cf_tag0", K_TAG, 0, 9);
        push("cf_tag1", K_TAG, 1, 9);
        drain();
        repeat (10) @(negedge clk);
        push("cf_err_sticky", K_ERR, 0, 1);
        push("cf_wv_idle", K_WV, 0, 0);
        push("cf_tag0_hold", K_TAG, 0, 9);
        drain();

        // alloc p12 with a stale write, plus an independent write to p13
        @(negedge clk);
        rd_all(12);
        rd_addr[1*PW +: PW] = 6'd13;
        alloc(12);
        wr(0, 12, 32'h55);
        wr(1, 13, 32'h66);
        push("stale_nobyp_rdy", K_RDY, 0, 0);
        push("stale_nobyp_data", K_DATA, 0, 0);
        push("indep_byp", K_DATA, 1, 32'h66);
        push("indep_byp_rdy", K_RDY, 1, 1);
        drain();
        @(negedge clk);
        idle();
        push("stale_data", K_DATA, 2, 32'h55);
        push("stale_rdy", K_RDY, 2, 0);
        push("indep_data", K_DATA, 1, 32'h66);
        push("indep_rdy", K_RDY, 1, 1);
        push("stale_wv", K_WV, 0, 2);
        push("stale_tag0_hold", K_TAG, 0, 9);
        push("indep_tag1", K_TAG, 1, 13);
        drain();

        // writes and allocation targeting p0
        @(negedge clk);
        rd_all(0);
        wr(0, 0, 32'hFFFF);
        alloc(0);
        push("p0_byp_data", K_DATA, 0, 0);
        push("p0_byp_rdy", K_RDY, 0, 1);
        drain();
        @(negedge clk);
        idle();
        push("p0_data", K_DATA, 3, 0);
        push("p0_rdy", K_RDY, 3, 1);
        push("p0_wv", K_WV, 0, 0);
        push("p0_err", K_ERR, 0, 1);
        drain();

        // fill p20..p27 alternating ports, checking each wakeup
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr(i % 2, 20 + i, 32'hA5000000 | 32'(i * 17));
            @(negedge clk);
            idle();
            push("fill_wv", K_WV, 0, 32'(1 << (i % 2)));
            push("fill_tag", K_TAG, i % 2, 32'(20 + i));
            drain();
        end
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            for (int p = 0; p < NR; p++) begin
                rd_addr[p*PW +: PW] = PW'(20 + 4 * r + p);
                push("fill_data", K_DATA, p, 32'hA5000000 | 32'((4 * r + p) * 17));
                push("fill_rdy", K_RDY, p, 1);
            end
            drain();
        end

        // reset in the middle of a write burst
        @(negedge clk);
        rd_all(30);
        rd_addr[1*PW +: PW] = 6'd31;
        rd_addr[3*PW +: PW] = 6'd20;
        wr(0, 30, 32'h1234);
        wr(1, 31, 32'h5678);
        #1 rst = 1'b1;
        push("mr_byp_data", K_DATA, 0, 0);
        push("mr_byp_rdy", K_RDY, 1, 0);
        push("mr_data20", K_DATA, 3, 0);
        push("mr_rdy20", K_RDY, 3, 0);
        push("mr_wv", K_WV, 0, 0);
        push("mr_err", K_ERR, 0, 0);
        push("mr_tag1", K_TAG, 1, 0);
        drain();
        @(negedge clk);
        idle();
        rst = 1'b0;
        rd_addr[2*PW +: PW] = 6'd0;
        push("post_rst_p30", K_DATA, 0, 0);
        push("post_rst_rdy30", K_RDY, 0, 0);
        push("post_rst_rdy0", K_RDY, 2, 1);
        push("post_rst_err", K_ERR, 0, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/phys_regfile_mp.md
Name: phys_regfile_mp

Overview:
- Parametrised multi-port physical register file with per-register ready (valid) bits for the out-of-order core.
- Sits between rename/dispatch, which allocates pregs and clears ready, and the execute/writeback ports, which write data and set ready.
- Supplies operands and ready status to issue.
- Adds the following: multiple read and write ports, allocation-driven ready clear, optional same-cycle write bypass, a registered wakeup broadcast, and sticky write-conflict detection.

Parameters:
- XLEN, 32, data width.
- NUM_PREGS, 64, number of physical registers; must be a power of 2 and at least 2.
- NUM_RD, 4, number of read ports.
- NUM_WR, 2, number of write ports.
- BYPASS, 1: when 1, reads observe same-cycle writes; when 0, reads see registered state only.
- PW, $clog2(NUM_PREGS), preg index width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- alloc_en  in  1  rename allocates a preg this cycle.
- alloc_preg  in  PW  preg being allocated.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*PW  write indices; port k occupies bits [k*PW +: PW].
- wr_data  in  NUM_WR*XLEN  write data, packed the same way.
- rd_addr  in  NUM_RD*PW  read indices, packed.
- rd_data  out  NUM_RD*XLEN  read data, packed.
- rd_ready  out  NUM_RD  per-port ready bit of the addressed preg.
- wakeup_valid  out  NUM_WR  registered copy of the effective write enables.
- wakeup_tag  out  NUM_WR*PW  registered copy of the write indices.
- err_multi_wr  out  1  sticky flag: two enabled write ports hit the same nonzero preg.

Behaviour:
- Reset (async, rst=1):
  - All data = 0.
  - ready[i] = 0 for i != 0; ready[0] = 1.
  - wakeup_valid = 0, wakeup_tag = 0, err_multi_wr = 0.
  - rst asserted mid-operation discards all in-flight writes and allocations immediately.
- Preg 0:
  - Hardwired: reads return 0 with ready = 1.
  - Writes to 0 are ignored, and excluded from wakeup and conflict checks.
  - alloc_preg = 0 is ignored.
- Write (posedge):
  - For each port k with wr_en[k] and wr_addr[k] != 0: data[addr] <= wr_data[k]; ready[addr] <= 1.
  - Same-address conflict between ports: the lowest-index port wins the data. err_multi_wr <= 1 and stays set until reset.
- Allocate (posedge):
  - alloc_en with alloc_preg != 0: ready[alloc_preg] <= 0; data unchanged.
  - Alloc and write to the same preg in the same cycle: the write's data is stored, but ready ends at 0. Allocation starts a new lifetime, so the write is stale.
  - Different pregs: both take effect independently.
- Read (combinational, 0-cycle):
  - BYPASS=0: rd_data/rd_ready reflect state as of the last clock edge.
  - BYPASS=1: if an enabled write port this cycle targets rd_addr (nonzero), rd_data = that port's wr_data (lowest index on conflict) and rd_ready = 1.
  - The bypass is suppressed when alloc_en targets the same preg that cycle; rd_ready then comes from the state-based path.
- Wakeup:
  - One cycle after a write edge: wakeup_valid[k] = 1 iff wr_en[k] was high and its addr was != 0 and not equal to alloc_preg (when alloc_en).
  - wakeup_tag[k] = wr_addr[k].
  - Both ports are reported even on a same-address conflict.
  - Otherwise wakeup_valid = 0. The tag holds its last value when valid = 0.
- No stall or backpressure: every enabled write completes in one cycle.
- Read-port count does not affect timing.

Test Plan:
- Reset, then read p0 and p5 on all ports -> p0: data 0, ready 1; p5: data 0, ready 0; err_multi_wr 0; wakeup_valid 0.
- Alloc p7, then next cycle write p7 = 0xDEADBEEF on port 1 -> the cycle after alloc, ready(p7)=0. During the write cycle with BYPASS=1: rd_data=0xDEADBEEF, rd_ready=1. Next cycle: stored, wakeup_valid=2'b10, wakeup_tag[1]=7.
- Same cycle: port0 writes p9=0x11, port1 writes p9=0x22 -> stored 0x11, ready(p9)=1, err_multi_wr=1 and still 1 after 10 idle cycles; wakeup_valid=2'b11.
- Same cycle: alloc p12 and port0 writes p12=0x55 -> data(p12)=0x55, ready(p12)=0, no bypass (rd_ready=0 that cycle), wakeup_valid[0]=0.
- Write p0=0xFFFF on port0 together with alloc p0 -> reads of p0 return 0, ready 1; wakeup_valid=0; err unchanged. Then assert rst mid-burst of writes -> all outputs return to reset values immediately.
